// File: rtl/sqrt_refine.sv
// sqrt_refine: refines an approximate 16-bit square-root seed into the exact
// integer floor root and remainder of a 32-bit radicand. Newton-Raphson steps
// share one restoring serial divider; a final +/-1 walk makes the result exact.
module sqrt_refine #(
  parameter int ITERS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [15:0] in_seed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_root,
  output logic [16:0] out_rem,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DIV    = 3'd1,
    S_UPDATE = 3'd2,
    S_FIX    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d;           // radicand
  logic [15:0] y_q, y_d;           // current root estimate, never 0
  logic [31:0] work_q, work_d;     // dividend shifting out, quotient shifting in
  logic [15:0] prem_q, prem_d;     // partial remainder, always < y
  logic [4:0]  cnt_q, cnt_d;       // divider bit counter
  logic [2:0]  iter_q, iter_d;     // Newton-Raphson iteration counter
  logic        out_valid_q, out_valid_d;
  logic [15:0] out_root_q, out_root_d;
  logic [16:0] out_rem_q, out_rem_d;

  logic [16:0] shift_s;
  logic [16:0] diff_s;
  logic        fits_s;
  logic [32:0] sum_s;
  logic [32:0] half_s;
  logic [32:0] sq_s;
  logic [32:0] yp1_s;
  logic [32:0] sq1_s;
  logic [32:0] rem_s;

  // Datapath helpers: one restoring-division step, NR average, square tests.
  always_comb begin
    shift_s = {prem_q, work_q[31]};
    diff_s  = shift_s - {1'b0, y_q};
    fits_s  = (shift_s >= {1'b0, y_q});
    sum_s   = {17'd0, y_q} + {1'b0, work_q};
    half_s  = sum_s >> 1;
    sq_s    = {17'd0, y_q} * {17'd0, y_q};
    yp1_s   = {17'd0, y_q} + 33'd1;
    sq1_s   = yp1_s * yp1_s;
    rem_s   = {1'b0, a_q} - sq_s;
  end

  // Next-state and next-register values for the refinement sequence.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    y_d         = y_q;
    work_d      = work_q;
    prem_d      = prem_q;
    cnt_d       = cnt_q;
    iter_d      = iter_q;
    out_valid_d = out_valid_q;
    out_root_d  = out_root_q;
    out_rem_d   = out_rem_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d    = in_a;
          y_d    = (in_seed == 16'd0) ? 16'd1 : in_seed;
          work_d = in_a;
          prem_d = 16'd0;
          cnt_d  = 5'd0;
          iter_d = 3'd0;
          if (in_a == 32'd0) begin
            // Zero radicand needs no refinement.
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            out_root_d  = 16'd0;
            out_rem_d   = 17'd0;
          end else begin
            state_d = S_DIV;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DIV: begin
        prem_d = fits_s ? diff_s[15:0] : shift_s[15:0];
        work_d = {work_q[30:0], fits_s};
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_UPDATE;
        end else begin
          state_d = S_DIV;
        end
      end
      S_UPDATE: begin
        // work_q now holds floor(a / y); average it with y, clamped to 16 bits.
        y_d    = (half_s > 33'h0_0000_FFFF) ? 16'hFFFF : half_s[15:0];
        iter_d = iter_q + 3'd1;
        work_d = a_q;
        prem_d = 16'd0;
        cnt_d  = 5'd0;
        if ((iter_q + 3'd1) == 3'(ITERS)) begin
          state_d = S_FIX;
        end else begin
          state_d = S_DIV;
        end
      end
      S_FIX: begin
        if (sq_s > {1'b0, a_q}) begin
          y_d = y_q - 16'd1;
        end else if ((y_q != 16'hFFFF) && (sq1_s <= {1'b0, a_q})) begin
          y_d = y_q + 16'd1;
        end else begin
          out_root_d  = y_q;
          out_rem_d   = rem_s[16:0];
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= 32'd0;
      y_q         <= 16'd0;
      work_q      <= 32'd0;
      prem_q      <= 16'd0;
      cnt_q       <= 5'd0;
      iter_q      <= 3'd0;
      out_valid_q <= 1'b0;
      out_root_q  <= 16'd0;
      out_rem_q   <= 17'd0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      y_q         <= y_d;
      work_q      <= work_d;
      prem_q      <= prem_d;
      cnt_q       <= cnt_d;
      iter_q      <= iter_d;
      out_valid_q <= out_valid_d;
      out_root_q  <= out_root_d;
      out_rem_q   <= out_rem_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_root  = out_root_q;
  assign out_rem   = out_rem_q;

endmodule

// File: doc/sqrt_refine.md
Name: sqrt_refine

Overview:
- Sequential stage directly downstream of the combinational approximate square-root datapath.
- Takes the 32-bit radicand plus the 16-bit approximate root (seed) from that datapath.
- Refines the seed by Newton-Raphson iterations on a shared serial divider, then corrects by ±1 steps.
- Returns the exact integer floor square root and its remainder over a valid/ready handshake.

Parameters:
ITERS, 2, number of Newton-Raphson iterations before correction (1..7)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_a/in_seed valid
in_ready  output  1  block can accept an operand (high only in IDLE)
in_a  input  32  unsigned radicand A
in_seed  input  16  approximate root from the upstream sqrt datapath
out_valid  output  1  result valid, held until accepted
out_ready  input  1  consumer accepts result
out_root  output  16  floor(sqrt(A))
out_rem  output  17  A - out_root^2 (always <= 2*out_root)
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, out_valid=0, out_root=0, out_rem=0, busy=0, internal counters 0.
  - in_ready=1, since it is decoded from state==IDLE.
  - Reset mid-operation abandons the operation with no output.
- States: IDLE, DIV, UPDATE, FIX, DONE.
- IDLE:
  - Accept on in_valid & in_ready at a rising edge; register a=in_a, y=in_seed.
  - in_seed==0 is replaced by y=1.
  - a==0 goes to DONE with root 0, rem 0. Otherwise go to DIV with iter=0.
- DIV:
  - Restoring division, one quotient bit per cycle, exactly 32 cycles.
  - Computes q=floor(a/y) as 32 bits; y>=1 always, so there is no divide-by-zero.
- UPDATE (1 cycle):
  - y <= min((y+q)>>1, 16'hFFFF), with the sum computed at 33 bits.
  - iter <= iter+1.
  - If iter+1==ITERS go to FIX, else go to DIV.
- FIX (1 cycle per decision; squares computed at 33 bits):
  - If y*y > a: y<=y-1, stay in FIX.
  - Else if y!=16'hFFFF and (y+1)^2 <= a: y<=y+1, stay in FIX.
  - Else: out_root<=y, out_rem<=a-y*y, go to DONE.
- DONE:
  - out_valid=1; out_root and out_rem held stable while out_ready is low.
  - On out_valid & out_ready: out_valid<=0, go to IDLE. in_ready rises the following cycle, so there is no same-cycle accept.
- Latency:
  - From accept edge E, out_valid goes high after edge E + ITERS*33 + 1 + C, where C is the number of ±1 corrections.
  - The a==0 path takes exactly 1 cycle.
- in_valid is ignored while busy; operands change only at an accept.
- The result is exact for every 32-bit A and every seed, including seed 0 and seed 16'hFFFF. FIX terminates because y moves monotonically toward the root.

Test Plan:
1. a=0, any seed, out_ready=1 -> out_valid one cycle after accept; out_root=0, out_rem=0.
2. a=1000000, seed=1000, ITERS=2 -> out_valid at E+67; out_root=1000, out_rem=0.
3. a=100, seed=0, ITERS=2 -> y goes 50 then 26, followed by 16 decrements; out_valid at E+83; out_root=10, out_rem=0.
4. a=32'hFFFFFFFF, seed=16'hFFFF -> out_root=16'hFFFF, out_rem=17'h1FFFE; clamp and no-increment guard exercised.
5. a=1000000, seed=1000, out_ready held low 10 cycles after out_valid:
   - out_root and out_rem stay stable; in_ready stays 0; a second in_valid pulse is ignored.
   - After the out_ready handshake, in_ready=1 on the next cycle.
6. rst_n pulsed low mid-DIV:
   - out_valid=0, busy=0, in_ready=1 immediately with no clock edge.
   - A following a=17, seed=4 yields out_root=4, out_rem=1.
